// File: rtl/pdp8_mem_arb.sv
// pdp8_mem_arb: shares the single pdp8_ram port between the CPU and a DMA requester,
// sequencing each access as strobe, wait and acknowledge, with DMA anti-starvation.
module pdp8_mem_arb #(
    parameter int RAM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [14:0] cpu_addr,
    input  logic [11:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [11:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_wr,
    input  logic [14:0] dma_addr,
    input  logic [11:0] dma_wdata,
    output logic        dma_ack,
    output logic [11:0] dma_rdata,
    output logic [14:0] ram_addr,
    output logic [11:0] ram_data_out,
    input  logic [11:0] ram_data_in,
    output logic        ram_rd,
    output logic        ram_wr,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int WW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);
    localparam logic [WW-1:0] LAST = WW'(RAM_LAT - 1);
    state_t state, state_nx;
    logic [SW-1:0] starve;
    logic [WW-1:0] wcnt;
    logic wr_q;
    logic grant, dma_win, last_wait;
    always_comb begin
        state_nx  = state;
        grant     = (state == IDLE) && (cpu_req || dma_req);
        dma_win   = dma_req && (!cpu_req || starve >= LIM);
        last_wait = (state == WAIT) && (wcnt == LAST);
        case (state)
            IDLE:    state_nx = grant ? ACCESS : IDLE;
            ACCESS:  state_nx = WAIT;
            WAIT:    state_nx = last_wait ? ACK : WAIT;
            default: state_nx = IDLE;
        endcase
        ram_rd  = (state == ACCESS) && !wr_q;
        ram_wr  = (state == ACCESS) && wr_q;
        cpu_ack = (state == ACK) && !owner;
        dma_ack = (state == ACK) && owner;
        busy    = state != IDLE;
    end
    // the access latch doubles as the ram bus drivers, so they hold while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            starve       <= '0;
            wcnt         <= '0;
            wr_q         <= 1'b0;
            owner        <= 1'b0;
            ram_addr     <= '0;
            ram_data_out <= '0;
            cpu_rdata    <= '0;
            dma_rdata    <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (grant) begin
                owner        <= dma_win;
                wr_q         <= dma_win ? dma_wr : cpu_wr;
                ram_addr     <= dma_win ? dma_addr : cpu_addr;
                ram_data_out <= dma_win ? dma_wdata : cpu_wdata;
                starve       <= (dma_win || !dma_req) ? '0 : (starve >= LIM) ? starve : starve + 1'b1;
            end
            if (last_wait && !wr_q && owner) dma_rdata <= ram_data_in;
            if (last_wait && !wr_q && !owner) cpu_rdata <= ram_data_in;
        end
    end
endmodule

// File: tb/tb_pdp8_mem_arb.sv
// tb_pdp8_mem_arb: randomized and directed checks of pdp8_mem_arb against a
// transaction-level memory/arbitration model, with a simple pdp8_ram behind it.
module tb_pdp8_mem_arb;
    localparam int RAM_LAT      = 1;
    localparam int STARVE_LIMIT = 4;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0, dma_req = 1'b0, dma_wr = 1'b0;
    logic [14:0] cpu_addr = '0, dma_addr = '0;
    logic [11:0] cpu_wdata = '0, dma_wdata = '0;
    logic        cpu_ack, dma_ack, ram_rd, ram_wr, owner, busy;
    logic [11:0] cpu_rdata, dma_rdata, ram_data_out, ram_data_in;
    logic [14:0] ram_addr;
    logic [11:0] mem [0:32767];
    logic [11:0] ram_q = '0;
    int checks = 0, failures = 0;
    int both_acks = 0, both_strobes = 0;
    bit ack_log[$];

    always #5 clk = ~clk;

    pdp8_mem_arb #(.RAM_LAT(RAM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .owner(owner), .busy(busy)
    );

    // pdp8_ram stand-in: read data valid one cycle after the ram_rd strobe
    always @(posedge clk) begin
        if (ram_rd) ram_q <= mem[ram_addr];
        if (ram_wr) mem[ram_addr] <= ram_data_out;
    end
    assign ram_data_in = ram_q;

    always @(posedge clk) if (reset) begin
        if (cpu_ack) ack_log.push_back(1'b0);
        if (dma_ack) ack_log.push_back(1'b1);
        if (cpu_ack && dma_ack) both_acks++;
        if (ram_rd && ram_wr) both_strobes++;
    end

    task automatic access(input bit d, input bit w, input logic [14:0] a, input logic [11:0] v,
                          output logic [11:0] rd, output int lat);
        lat = 0;
        if (d) begin dma_req = 1'b1; dma_wr = w; dma_addr = a; dma_wdata = v; end
        else begin cpu_req = 1'b1; cpu_wr = w; cpu_addr = a; cpu_wdata = v; end
        do begin
            @(negedge clk);
            lat++;
        end while (!(d ? dma_ack : cpu_ack) && lat < 40);
        if (d) dma_req = 1'b0; else cpu_req = 1'b0;
        rd = d ? dma_rdata : cpu_rdata;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, owner, cpu_ack, dma_ack, ram_rd, ram_wr} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, owner, cpu_ack, dma_ack, ram_rd, ram_wr});
        end
        checks++;
        if (ram_addr !== 15'd0 || ram_data_out !== 12'd0) begin
            failures++; $display("FAIL reset_bus: got addr %0o data %0o expected 0 0", ram_addr, ram_data_out);
        end
        checks++;
        if (cpu_rdata !== 12'd0 || dma_rdata !== 12'd0) begin
            failures++; $display("FAIL reset_rdata: got %0o %0o expected 0 0", cpu_rdata, dma_rdata);
        end
        reset = 1'b1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'o00200;
        @(negedge clk);
        checks++;
        if (ram_rd !== 1'b1) begin
            failures++; $display("FAIL rst_pre_access: got ram_rd %b expected 1", ram_rd);
        end
        #2 reset = 1'b0; cpu_req = 1'b0;
        #1;
        checks++;
        if ({ram_rd, ram_wr, cpu_ack, dma_ack, busy} !== 5'b0) begin
            failures++; $display("FAIL rst_async_drop: got %b expected 00000", {ram_rd, ram_wr, cpu_ack, dma_ack, busy});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cpu_rdata !== 12'd0 || cpu_ack !== 1'b0) begin
            failures++; $display("FAIL rst_release: got busy %b rdata %0o ack %b expected 0 0 0", busy, cpu_rdata, cpu_ack);
        end
    endtask

    task automatic test_cpu_read();
        logic [11:0] rd;
        int lat;
        access(1'b1, 1'b1, 15'o00200, 12'o1234, rd, lat);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'o00200;
        @(negedge clk);
        checks++;
        if (ram_rd !== 1'b1 || ram_wr !== 1'b0 || ram_addr !== 15'o00200 || owner !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL cpu_rd_strobe: got rd %b wr %b addr %0o owner %b busy %b expected 1 0 200 0 1", ram_rd, ram_wr, ram_addr, owner, busy);
        end
        @(negedge clk);
        checks++;
        if (ram_rd !== 1'b0 || busy !== 1'b1 || cpu_ack !== 1'b0 || ram_addr !== 15'o00200) begin
            failures++; $display("FAIL cpu_rd_wait: got rd %b busy %b ack %b addr %0o expected 0 1 0 200", ram_rd, busy, cpu_ack, ram_addr);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1 || dma_ack !== 1'b0 || cpu_rdata !== 12'o1234) begin
            failures++; $display("FAIL cpu_rd_ack: got ack %b dack %b rdata %0o expected 1 0 1234", cpu_ack, dma_ack, cpu_rdata);
        end
        cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b0 || busy !== 1'b0 || cpu_rdata !== 12'o1234 || ram_addr !== 15'o00200) begin
            failures++; $display("FAIL cpu_rd_hold: got ack %b busy %b rdata %0o addr %0o expected 0 0 1234 200", cpu_ack, busy, cpu_rdata, ram_addr);
        end
    endtask

    task automatic test_dma_write();
        logic [11:0] rd;
        int lat;
        access(1'b1, 1'b1, 15'o00300, 12'o5252, rd, lat);
        @(negedge clk);
        access(1'b1, 1'b0, 15'o00300, 12'o0, rd, lat);
        checks++;
        if (rd !== 12'o5252 || lat != 2 + RAM_LAT) begin
            failures++; $display("FAIL dma_rd: got %0o lat %0d expected 5252 lat %0d", rd, lat, 2 + RAM_LAT);
        end
        @(negedge clk);
        access(1'b1, 1'b1, 15'o10017, 12'o7777, rd, lat);
        checks++;
        if (dma_rdata !== 12'o5252 || lat != 2 + RAM_LAT) begin
            failures++; $display("FAIL dma_wr_keeps_rdata: got %0o lat %0d expected 5252 lat %0d", dma_rdata, lat, 2 + RAM_LAT);
        end
        @(negedge clk);
        access(1'b0, 1'b0, 15'o10017, 12'o0, rd, lat);
        checks++;
        if (rd !== 12'o7777) begin
            failures++; $display("FAIL cpu_rd_after_dma_wr: got %0o expected 7777", rd);
        end
    endtask

    task automatic test_contention();
        logic [11:0] rd;
        int lat, s;
        bit exp_d;
        access(1'b0, 1'b0, 15'o00200, 12'o0, rd, lat);
        @(negedge clk);
        ack_log.delete();
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'o00200;
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 15'o10017;
        for (int i = 0; i < 80 && ack_log.size() < 10; i++) @(negedge clk);
        cpu_req = 1'b0; dma_req = 1'b0;
        checks++;
        if (ack_log.size() < 10) begin
            failures++; $display("FAIL contention_timeout: got %0d grants expected 10", ack_log.size());
        end else begin
            s = 0;
            for (int i = 0; i < 10; i++) begin
                exp_d = s >= STARVE_LIMIT;
                s = exp_d ? 0 : (s < STARVE_LIMIT ? s + 1 : s);
                checks++;
                if (ack_log[i] !== exp_d) begin
                    failures++; $display("FAIL contention_order[%0d]: got %s expected %s", i, ack_log[i] ? "D" : "C", exp_d ? "D" : "C");
                end
            end
        end
        repeat (8) @(negedge clk);
        checks++;
        if (both_acks != 0 || both_strobes != 0) begin
            failures++; $display("FAIL contention_exclusive: got %0d dual acks %0d dual strobes expected 0 0", both_acks, both_strobes);
        end
    endtask

    task automatic test_simultaneous();
        logic [11:0] crd, drd, rd;
        int clat, dlat, lat;
        access(1'b0, 1'b0, 15'o00300, 12'o0, rd, lat);
        @(negedge clk);
        ack_log.delete();
        fork
            access(1'b0, 1'b0, 15'o00200, 12'o0, crd, clat);
            access(1'b1, 1'b0, 15'o10017, 12'o0, drd, dlat);
        join
        @(negedge clk);
        checks++;
        if (ack_log.size() != 2 || ack_log[0] !== 1'b0 || ack_log[1] !== 1'b1) begin
            failures++; $display("FAIL simul_order: got %0d grants first %b expected 2 grants C then D", ack_log.size(), ack_log.size() > 0 ? ack_log[0] : 1'b1);
        end
        checks++;
        if (crd !== 12'o1234 || drd !== 12'o7777) begin
            failures++; $display("FAIL simul_data: got %0o %0o expected 1234 7777", crd, drd);
        end
        checks++;
        if (clat != 2 + RAM_LAT || dlat != 5 + 2 * RAM_LAT) begin
            failures++; $display("FAIL simul_latency: got %0d %0d expected %0d %0d", clat, dlat, 2 + RAM_LAT, 5 + 2 * RAM_LAT);
        end
        checks++;
        if (both_acks != 0) begin
            failures++; $display("FAIL simul_dual_ack: got %0d expected 0", both_acks);
        end
    endtask

    task automatic test_withdraw();
        logic [14:0] a;
        logic [11:0] v, rd;
        int lat;
        a = 15'o04000 | 15'($urandom_range(4095));
        v = 12'($urandom);
        ack_log.delete();
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = v;
        @(negedge clk);
        checks++;
        if (ram_wr !== 1'b1 || ram_rd !== 1'b0 || ram_addr !== a || ram_data_out !== v) begin
            failures++; $display("FAIL wd_write_strobe: got wr %b rd %b addr %0o data %0o expected 1 0 %0o %0o", ram_wr, ram_rd, ram_addr, ram_data_out, a, v);
        end
        cpu_addr = a ^ 15'd1; cpu_wdata = ~v;
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 15'o00300;
        @(negedge clk);
        dma_req = 1'b0;
        checks++;
        if (ram_addr !== a || ram_data_out !== v) begin
            failures++; $display("FAIL wd_addr_latched: got %0o %0o expected %0o %0o", ram_addr, ram_data_out, a, v);
        end
        @(negedge clk);
        checks++;
        if (cpu_ack !== 1'b1) begin
            failures++; $display("FAIL wd_cpu_ack: got %b expected 1", cpu_ack);
        end
        cpu_req = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (ack_log.size() != 1 || ack_log[0] !== 1'b0) begin
            failures++; $display("FAIL wd_no_dma_ack: got %0d acks expected 1 cpu ack only", ack_log.size());
        end
        access(1'b0, 1'b0, a, 12'o0, rd, lat);
        checks++;
        if (rd !== v) begin
            failures++; $display("FAIL wd_readback: got %0o expected %0o", rd, v);
        end
    endtask

    task automatic test_random();
        logic [14:0] pool [8];
        logic [11:0] ref_mem [8];
        logic [11:0] v, rd;
        bit d, w;
        int k, g, lat, nc, nd, gc, gd;
        for (int i = 0; i < 8; i++) pool[i] = {3'(i), 12'($urandom)};
        nc = 0; nd = 0;
        @(negedge clk);
        ack_log.delete();
        for (int i = 0; i < 48; i++) begin
            d = 1'($urandom_range(1));
            w = (i < 8) ? 1'b1 : 1'($urandom_range(1));
            k = (i < 8) ? i : $urandom_range(7);
            v = 12'($urandom);
            g = (i == 0) ? 1 : $urandom_range(2);
            repeat (g) @(negedge clk);
            access(d, w, pool[k], v, rd, lat);
            checks++;
            if (lat != (g == 0 ? 3 + RAM_LAT : 2 + RAM_LAT)) begin
                failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, g == 0 ? 3 + RAM_LAT : 2 + RAM_LAT);
            end
            if (w) ref_mem[k] = v;
            else begin
                checks++;
                if (rd !== ref_mem[k]) begin
                    failures++; $display("FAIL rand_rdata[%0d]: got %0o expected %0o at %0o", i, rd, ref_mem[k], pool[k]);
                end
            end
            if (d) nd++; else nc++;
        end
        @(negedge clk);
        gc = 0; gd = 0;
        foreach (ack_log[i]) if (ack_log[i]) gd++; else gc++;
        checks++;
        if (gc != nc || gd != nd) begin
            failures++; $display("FAIL rand_ack_counts: got cpu %0d dma %0d expected %0d %0d", gc, gd, nc, nd);
        end
        checks++;
        if (both_acks != 0 || both_strobes != 0) begin
            failures++; $display("FAIL rand_exclusive: got %0d %0d expected 0 0", both_acks, both_strobes);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_contention();
        test_simultaneous();
        test_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
